rseq_ring: RTL and testbench
============================

Name: rseq_ring

Overview:
- Parametrised successor to the fixed 4-state cyclic sequencer: a ring of STATES states, advanced by qualifier `a`.
- Adds:
  - selectable state encoding (binary or Gray, optionally XOR-scrambled)
  - up/down direction
  - synchronous load
  - wrap pulse
  - illegal-encoding detection
- Used as a sequencing primitive in control paths and as a configurable subject for encoding-equivalence checks: two instances differing only in ENC/ENC_MASK must produce identical `x`, `idx` and `wrap` behaviour.

Parameters:
- STATES, 4, number of ring states; legal range 2..256.
- W, $clog2(STATES), width of state register and index (derived; do not override).
- ENC, 0, state encoding: 0 = binary of index, 1 = Gray of index (i ^ (i>>1)).
- ENC_MASK, 0, W-bit XOR mask applied after ENC encoding; stored state = enc(i) ^ ENC_MASK.
- RST_IDX, 0, index loaded at reset; must be < STATES.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- a  in  1  advance qualifier; one step per cycle when high.
- dir  in  1  0 = step up (i+1), 1 = step down (i-1).
- ld  in  1  synchronous load request.
- ld_idx  in  W  index to load when ld=1.
- r_q  out  W  encoded state register (registered).
- idx  out  W  decoded index of r_q (combinational from r_q).
- x  out  1  ^r_q, reduction XOR of encoded state.
- wrap  out  1  registered one-cycle pulse on ring wrap.
- err  out  1  registered one-cycle pulse on bad load or illegal state.

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous, active-low.
- State storage:
  - r_q holds the encoded value, never the plain index.
  - Decode: idx = dec(r_q ^ ENC_MASK), where dec = identity (ENC=0) or Gray-to-binary (ENC=1).
- Reset (rstn=0 at posedge):
  - r_q = enc(RST_IDX) ^ ENC_MASK
  - wrap = 0, err = 0
  - x follows ^r_q
  - reset overrides ld and a in the same cycle.
- Priority per cycle: rstn low > illegal-state handling > ld > a > hold.
- Load (ld=1):
  - If ld_idx < STATES: r_q <= enc(ld_idx)^ENC_MASK; wrap=0; err=0.
  - If ld_idx >= STATES: r_q holds; err=1 for one cycle.
  - ld never asserts wrap; `a` is ignored in a load cycle.
- Advance (ld=0, a=1):
  - dir=0: i -> (i==STATES-1) ? 0 : i+1. Wrap STATES-1 -> 0 sets wrap=1 on the next cycle.
  - dir=1: i -> (i==0) ? STATES-1 : i-1. Wrap 0 -> STATES-1 sets wrap=1.
  - dir may change every cycle; each step uses the dir sampled that cycle.
- Hold (ld=0, a=0): r_q unchanged, wrap=0, err=0.
- Illegal state (decoded idx >= STATES; reachable only when STATES is not a power of two, via fault or force): behaviour set by the optional feature below.
- Latency:
  - r_q updates at the posedge where the request is sampled.
  - idx and x are valid in the same cycle as r_q.
  - wrap and err are asserted for exactly the cycle following the causing edge.
- STATES = 2^W: every encoding is legal and err is only ever raised by a bad load.

Optional Feature:
- Macro: RSEQ_ILLEGAL_RECOVER_EN.
- Defined: when r_q decodes to idx >= STATES and rstn=1, the next edge forces r_q = enc(RST_IDX)^ENC_MASK and err=1 for one cycle. This takes priority over ld and a.
- Undefined:
  - An illegal r_q holds its value; ld with a legal ld_idx is still the only exit.
  - err is raised only by a bad load; `a` has no effect in an illegal state.
  - No X assignment in either build.

Test Plan:
- Basic cycling: STATES=4, ENC=0, ENC_MASK=0, reset then a=1, dir=0 for 5 cycles -> idx 0,1,2,3,0,1; x 0,1,1,0,0,1; wrap high only in the cycle after 3->0.
- Gray + mask: STATES=4, ENC=1, ENC_MASK=2'b10, a=1 -> r_q 10,11,01,00,10; idx 0,1,2,3,0; x 1,0,1,0,1.
- Down count: STATES=5, dir=1, a=1 from RST_IDX=0 -> idx 4,3,2,1,0,4; wrap pulse after 0->4 and after the second 0->4 only.
- Load and priority: STATES=5, ld=1 with ld_idx=3 and a=1 -> idx=3, no wrap. Then ld_idx=6 -> idx stays 3, err=1 for one cycle. rstn=0 together with ld=1 -> idx=RST_IDX.
- Illegal state: STATES=5, force r_q=3'b110, a=1:
  - with RSEQ_ILLEGAL_RECOVER_EN -> next cycle idx=0, err=1.
  - without it -> r_q stays 110, err=0.
  - then ld=1 with ld_idx=2 -> idx=2.
- Equivalence: two instances (ENC=0, mask 0 vs ENC=1, mask 1) driven with a 1000-cycle random stream of a/dir/ld/ld_idx -> idx and wrap match every cycle.

Source files
------------

// File: rtl/rseq_ring.sv
// rtl/rseq_ring.sv - parametrised encoded ring sequencer; RSEQ_ILLEGAL_RECOVER_EN enables illegal-state recovery
module rseq_ring #(
    parameter int              STATES   = 4,
    parameter int              W        = (STATES > 1) ? $clog2(STATES) : 1,
    parameter int              ENC      = 0,
    parameter logic [W-1:0]    ENC_MASK = '0,
    parameter int              RST_IDX  = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         a,
    input  logic         dir,
    input  logic         ld,
    input  logic [W-1:0] ld_idx,
    output logic [W-1:0] r_q,
    output logic [W-1:0] idx,
    output logic         x,
    output logic         wrap,
    output logic         err
);

    function automatic logic [W-1:0] enc_f(input logic [W-1:0] i);
        if (ENC == 1) return i ^ (i >> 1);
        return i;
    endfunction

    function automatic logic [W-1:0] dec_f(input logic [W-1:0] g);
        logic [W-1:0] b;
        if (ENC != 1) return g;
        b[W-1] = g[W-1];
        for (int k = W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    localparam logic [W:0]   N_STATES = (W+1)'(STATES);
    localparam logic [W-1:0] LAST_IDX = W'(STATES - 1);
    localparam logic [W-1:0] RST_ENC  = enc_f(W'(RST_IDX)) ^ ENC_MASK;

    logic [W-1:0] r_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic [W-1:0] nxt_idx;
    logic         illegal;
    logic         ld_ok;

    assign idx     = dec_f(r_q ^ ENC_MASK);
    assign x       = ^r_q;
    assign wrap    = wrap_q;
    assign err     = err_q;
    assign illegal = {1'b0, idx} >= N_STATES;
    assign ld_ok   = {1'b0, ld_idx} < N_STATES;

    always_comb begin
        r_d     = r_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        nxt_idx = idx;
        if (illegal) begin
`ifdef RSEQ_ILLEGAL_RECOVER_EN
            r_d   = RST_ENC;
            err_d = 1'b1;
`else
            // Without recovery only a legal load leaves an illegal state.
            if (ld) begin
                if (ld_ok) r_d = enc_f(ld_idx) ^ ENC_MASK;
                else       err_d = 1'b1;
            end
`endif
        end else if (ld) begin
            if (ld_ok) r_d = enc_f(ld_idx) ^ ENC_MASK;
            else       err_d = 1'b1;
        end else if (a) begin
            if (!dir) begin
                if (idx == LAST_IDX) begin
                    nxt_idx = '0;
                    wrap_d  = 1'b1;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end else begin
                if (idx == '0) begin
                    nxt_idx = LAST_IDX;
                    wrap_d  = 1'b1;
                end else begin
                    nxt_idx = idx - 1'b1;
                end
            end
            r_d = enc_f(nxt_idx) ^ ENC_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q    <= RST_ENC;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_rseq_ring.sv
// tb/tb_rseq_ring.sv - directed bench for rseq_ring
module tb_rseq_ring;

    logic       clk = 1'b0;
    logic       rstn, a, dir, ld;
    logic [2:0] ld_idx;

    int errors = 0;
    int checks = 0;

    logic [1:0] b4_r, b4_idx, g4_r, g4_idx;
    logic       b4_x, b4_wrap, b4_err, g4_x, g4_wrap, g4_err;
    logic [2:0] d5_r, d5_idx, e0_r, e0_idx, e1_r, e1_idx;
    logic       d5_x, d5_wrap, d5_err, e0_x, e0_wrap, e0_err, e1_x, e1_wrap, e1_err;

    always #5 clk = ~clk;

    rseq_ring #(.STATES(4), .ENC(0), .ENC_MASK(2'b00)) u_b4 (
        .clk(clk), .rstn(rstn), .a(a), .dir(dir), .ld(ld), .ld_idx(ld_idx[1:0]),
        .r_q(b4_r), .idx(b4_idx), .x(b4_x), .wrap(b4_wrap), .err(b4_err));

    rseq_ring #(.STATES(4), .ENC(1), .ENC_MASK(2'b10)) u_g4 (
        .clk(clk), .rstn(rstn), .a(a), .dir(dir), .ld(ld), .ld_idx(ld_idx[1:0]),
        .r_q(g4_r), .idx(g4_idx), .x(g4_x), .wrap(g4_wrap), .err(g4_err));

    rseq_ring #(.STATES(5), .ENC(0), .ENC_MASK(3'b000)) u_d5 (
        .clk(clk), .rstn(rstn), .a(a), .dir(dir), .ld(ld), .ld_idx(ld_idx),
        .r_q(d5_r), .idx(d5_idx), .x(d5_x), .wrap(d5_wrap), .err(d5_err));

    rseq_ring #(.STATES(5), .ENC(0), .ENC_MASK(3'b000)) u_e0 (
        .clk(clk), .rstn(rstn), .a(a), .dir(dir), .ld(ld), .ld_idx(ld_idx),
        .r_q(e0_r), .idx(e0_idx), .x(e0_x), .wrap(e0_wrap), .err(e0_err));

    rseq_ring #(.STATES(5), .ENC(1), .ENC_MASK(3'b001)) u_e1 (
        .clk(clk), .rstn(rstn), .a(a), .dir(dir), .ld(ld), .ld_idx(ld_idx),
        .r_q(e1_r), .idx(e1_idx), .x(e1_x), .wrap(e1_wrap), .err(e1_err));

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0; a = 1'b0; dir = 1'b0; ld = 1'b0; ld_idx = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (b4_idx !== 2'd0 || b4_x !== 1'b0 || b4_wrap !== 1'b0 || b4_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_b4 idx=%0d x=%0b wrap=%0b err=%0b expected 0/0/0/0", b4_idx, b4_x, b4_wrap, b4_err);
        end
        checks++;
        if (g4_r !== 2'b10 || g4_x !== 1'b1) begin
            errors++;
            $display("FAIL reset_g4 r_q=%b x=%0b expected 10/1", g4_r, g4_x);
        end
    endtask

    task automatic test_basic_cycling;
        int e_idx[6]  = '{0, 1, 2, 3, 0, 1};
        int e_x[6]    = '{0, 1, 1, 0, 0, 1};
        int e_wrap[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        a = 1'b1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (b4_idx !== 2'(e_idx[i]) || b4_x !== 1'(e_x[i]) || b4_wrap !== 1'(e_wrap[i])) begin
                errors++;
                $display("FAIL basic[%0d] idx=%0d x=%0b wrap=%0b expected %0d/%0d/%0d",
                         i, b4_idx, b4_x, b4_wrap, e_idx[i], e_x[i], e_wrap[i]);
            end
            if (i < 5) tick();
        end
        a = 1'b0;
    endtask

    task automatic test_gray_mask;
        int e_r[5]   = '{2, 3, 1, 0, 2};
        int e_idx[5] = '{0, 1, 2, 3, 0};
        int e_x[5]   = '{1, 0, 1, 0, 1};
        do_reset();
        a = 1'b1; dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (g4_r !== 2'(e_r[i]) || g4_idx !== 2'(e_idx[i]) || g4_x !== 1'(e_x[i])) begin
                errors++;
                $display("FAIL gray[%0d] r_q=%b idx=%0d x=%0b expected %0d/%0d/%0d",
                         i, g4_r, g4_idx, g4_x, e_r[i], e_idx[i], e_x[i]);
            end
            if (i < 4) tick();
        end
        a = 1'b0;
    endtask

    task automatic test_down_count;
        int e_idx[6]  = '{4, 3, 2, 1, 0, 4};
        int e_wrap[6] = '{1, 0, 0, 0, 0, 1};
        do_reset();
        a = 1'b1; dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (d5_idx !== 3'(e_idx[i]) || d5_wrap !== 1'(e_wrap[i])) begin
                errors++;
                $display("FAIL down[%0d] idx=%0d wrap=%0b expected %0d/%0d",
                         i, d5_idx, d5_wrap, e_idx[i], e_wrap[i]);
            end
        end
        a = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load_priority;
        do_reset();
        ld = 1'b1; ld_idx = 3'd3; a = 1'b1;
        tick();
        checks++;
        if (d5_idx !== 3'd3 || d5_wrap !== 1'b0 || d5_err !== 1'b0) begin
            errors++;
            $display("FAIL load_ok idx=%0d wrap=%0b err=%0b expected 3/0/0", d5_idx, d5_wrap, d5_err);
        end
        ld_idx = 3'd6;
        tick();
        checks++;
        if (d5_idx !== 3'd3 || d5_err !== 1'b1) begin
            errors++;
            $display("FAIL load_bad idx=%0d err=%0b expected 3/1", d5_idx, d5_err);
        end
        ld = 1'b0; a = 1'b0;
        tick();
        checks++;
        if (d5_idx !== 3'd3 || d5_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse idx=%0d err=%0b expected 3/0", d5_idx, d5_err);
        end
        rstn = 1'b0; ld = 1'b1; ld_idx = 3'd2; a = 1'b1;
        tick();
        checks++;
        if (d5_idx !== 3'd0 || d5_err !== 1'b0 || d5_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load idx=%0d err=%0b wrap=%0b expected 0/0/0", d5_idx, d5_err, d5_wrap);
        end
        rstn = 1'b1; ld = 1'b0; a = 1'b0;
    endtask

    task automatic test_illegal_state;
        do_reset();
        force u_d5.r_q = 3'b110;
        #1;
        release u_d5.r_q;
        #1;
        checks++;
        if (d5_idx !== 3'd6) begin
            errors++;
            $display("FAIL illegal_forced idx=%0d expected 6", d5_idx);
        end
        a = 1'b1;
        tick();
        checks++;
`ifdef RSEQ_ILLEGAL_RECOVER_EN
        if (d5_idx !== 3'd0 || d5_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_recover idx=%0d err=%0b expected 0/1", d5_idx, d5_err);
        end
`else
        if (d5_r !== 3'b110 || d5_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold r_q=%b err=%0b expected 110/0", d5_r, d5_err);
        end
`endif
        a = 1'b0; ld = 1'b1; ld_idx = 3'd2;
        tick();
        checks++;
        if (d5_idx !== 3'd2 || d5_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_exit idx=%0d err=%0b expected 2/0", d5_idx, d5_err);
        end
        ld = 1'b0;
    endtask

    task automatic test_equivalence;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            a      = 1'($urandom_range(0, 1));
            dir    = 1'($urandom_range(0, 1));
            ld     = ($urandom_range(0, 7) == 0);
            ld_idx = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (e0_idx !== e1_idx || e0_wrap !== e1_wrap || e0_err !== e1_err) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL equiv[%0d] enc1 idx=%0d wrap=%0b err=%0b expected %0d/%0d/%0d",
                             i, e1_idx, e1_wrap, e1_err, e0_idx, e0_wrap, e0_err);
            end
        end
        a = 1'b0; ld = 1'b0; dir = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; a = 1'b0; dir = 1'b0; ld = 1'b0; ld_idx = '0;
        @(negedge clk);
        test_reset();
        test_basic_cycling();
        test_gray_mask();
        test_down_count();
        test_load_priority();
        test_illegal_state();
        test_equivalence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
